// File: rtl/scan_timing_pkg.sv
// Shared timing constants for the text-mode raster scan path.
// Default geometry is 640x480 visible inside an 800x525 total raster.
package scan_timing_pkg;

  localparam int H_TOTAL_DEF   = 800;
  localparam int V_TOTAL_DEF   = 525;
  localparam int H_VISIBLE_DEF = 640;
  localparam int V_VISIBLE_DEF = 480;
  localparam int POS_W_DEF     = 10;
  localparam int IDX_W_DEF     = 19;

  localparam int HSYNC_START = 656;
  localparam int HSYNC_END   = 751;
  localparam int VSYNC_START = 490;
  localparam int VSYNC_END   = 491;

  // One font row covers one 8-pixel character cell.
  localparam int GLYPH_W   = 8;
  localparam int CELL_BITS = 3;

  localparam logic [7:0] RGB_ON  = 8'hFF;
  localparam logic [7:0] RGB_OFF = 8'h00;

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter: counts 0..MAX when enabled, wraps to 0, flags the top value.
module wrap_counter #(
  parameter int MAX = 799,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count == W'(MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= at_max ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/scan_timing_core.sv
// Raster scan engine: h/v position counters, visible-pixel index and glyph-row serialiser.
// Define SCAN_SYNC_OUTPUTS_EN to add the active-low hsync_n/vsync_n outputs.
module scan_timing_core
  import scan_timing_pkg::*;
#(
  parameter int H_TOTAL   = H_TOTAL_DEF,
  parameter int V_TOTAL   = V_TOTAL_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int POS_W     = POS_W_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [GLYPH_W-1:0] glyph_row_in,
  output logic [POS_W-1:0]   pixel_x,
  output logic [POS_W-1:0]   pixel_y,
  output logic [IDX_W-1:0]   pixel_index,
  output logic               visible,
  output logic               h_wrap,
  output logic               v_wrap,
  output logic               load_strobe,
  output logic [7:0]         red_out,
  output logic [7:0]         green_out,
  output logic [7:0]         blue_out
`ifdef SCAN_SYNC_OUTPUTS_EN
  ,
  output logic               hsync_n,
  output logic               vsync_n
`endif
);

  logic                 v_at_max;
  logic [CELL_BITS-1:0] cell_col;
  logic [GLYPH_W-1:0]   glyph_sreg;
  logic                 pixel_on;

  wrap_counter #(
    .MAX (H_TOTAL - 1),
    .W   (POS_W)
  ) u_h_counter (
    .clk    (clk),
    .reset  (reset),
    .en     (1'b1),
    .count  (pixel_x),
    .at_max (h_wrap)
  );

  wrap_counter #(
    .MAX (V_TOTAL - 1),
    .W   (POS_W)
  ) u_v_counter (
    .clk    (clk),
    .reset  (reset),
    .en     (h_wrap),
    .count  (pixel_y),
    .at_max (v_at_max)
  );

  assign v_wrap   = h_wrap && v_at_max;
  assign visible  = (pixel_x < POS_W'(H_VISIBLE)) && (pixel_y < POS_W'(V_VISIBLE));
  assign cell_col = pixel_x[CELL_BITS-1:0];

  // Loading on the last pixel of a cell, or at end of line, makes the next
  // cell's row ready exactly when its first pixel is displayed.
  assign load_strobe = (visible && (cell_col == CELL_BITS'(GLYPH_W - 1))) || h_wrap;

  // Frame wrap outranks the visible increment so the new frame starts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_index <= '0;
    end else if (v_wrap) begin
      pixel_index <= '0;
    end else if (visible) begin
      pixel_index <= pixel_index + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      glyph_sreg <= '0;
    end else if (load_strobe) begin
      glyph_sreg <= glyph_row_in;
    end else if (visible) begin
      glyph_sreg <= {glyph_sreg[GLYPH_W-2:0], 1'b0};
    end
  end

  // Blanking forces black even though the register may still hold a row.
  assign pixel_on  = visible && glyph_sreg[GLYPH_W-1];
  assign red_out   = pixel_on ? RGB_ON : RGB_OFF;
  assign green_out = pixel_on ? RGB_ON : RGB_OFF;
  assign blue_out  = pixel_on ? RGB_ON : RGB_OFF;

`ifdef SCAN_SYNC_OUTPUTS_EN
  assign hsync_n = !((pixel_x >= POS_W'(HSYNC_START)) && (pixel_x <= POS_W'(HSYNC_END)));
  assign vsync_n = !((pixel_y >= POS_W'(VSYNC_START)) && (pixel_y <= POS_W'(VSYNC_END)));
`endif

endmodule

// File: tb/tb_scan_timing_core.sv
// Bench for scan_timing_core: full-size instance for line-level vectors and
// a reduced-geometry instance streamed against a scoreboard over whole frames.
module tb_scan_timing_core;

  localparam int FH = 800, FV = 525, FHV = 640, FVV = 480;
  localparam int SH = 40, SV = 12, SHV = 24, SVV = 8;
  localparam int SB_W = 67;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] glyph_f = 8'h00;
  logic [7:0] glyph_s = 8'h00;

  logic [9:0]  f_x, f_y, s_x, s_y;
  logic [18:0] f_idx, s_idx;
  logic        f_vis, f_hw, f_vw, f_ld, s_vis, s_hw, s_vw, s_ld;
  logic [7:0]  f_r, f_g, f_b, s_r, s_g, s_b;
`ifdef SCAN_SYNC_OUTPUTS_EN
  logic f_hs, f_vs, s_hs, s_vs;
`endif

  int n_checks = 0;
  int n_err = 0;
  logic [SB_W-1:0] exp_q[$];

  scan_timing_core u_full (
    .clk          (clk),
    .reset        (reset),
    .glyph_row_in (glyph_f),
    .pixel_x      (f_x),
    .pixel_y      (f_y),
    .pixel_index  (f_idx),
    .visible      (f_vis),
    .h_wrap       (f_hw),
    .v_wrap       (f_vw),
    .load_strobe  (f_ld),
    .red_out      (f_r),
    .green_out    (f_g),
    .blue_out     (f_b)
`ifdef SCAN_SYNC_OUTPUTS_EN
    ,
    .hsync_n      (f_hs),
    .vsync_n      (f_vs)
`endif
  );

  scan_timing_core #(
    .H_TOTAL   (SH),
    .V_TOTAL   (SV),
    .H_VISIBLE (SHV),
    .V_VISIBLE (SVV)
  ) u_small (
    .clk          (clk),
    .reset        (reset),
    .glyph_row_in (glyph_s),
    .pixel_x      (s_x),
    .pixel_y      (s_y),
    .pixel_index  (s_idx),
    .visible      (s_vis),
    .h_wrap       (s_hw),
    .v_wrap       (s_vw),
    .load_strobe  (s_ld),
    .red_out      (s_r),
    .green_out    (s_g),
    .blue_out     (s_b)
`ifdef SCAN_SYNC_OUTPUTS_EN
    ,
    .hsync_n      (s_hs),
    .vsync_n      (s_vs)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit expired, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h) required %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  // scoreboard
  function automatic logic [SB_W-1:0] pack(input logic [9:0] x, input logic [9:0] y,
                                           input logic [18:0] idx, input logic vis,
                                           input logic hw, input logic vw, input logic ld,
                                           input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {x, y, idx, vis, hw, vw, ld, r, g, b};
  endfunction

  task automatic sb_compare(input int c);
    logic [SB_W-1:0] e;
    logic [SB_W-1:0] a;
    e = exp_q.pop_front();
    a = pack(s_x, s_y, s_idx, s_vis, s_hw, s_vw, s_ld, s_r, s_g, s_b);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL stream c=%0d: got %h required %h", c, a, e);
    end
  endtask

  task automatic run_small_stream(input int cycles, output int vw_seen);
    logic [7:0] row_m;
    row_m = 8'h00;
    vw_seen = 0;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      int x, y, idx;
      logic vis, hw, vw, ld, on;
      logic [7:0] col, g;
      x   = c % SH;
      y   = (c / SH) % SV;
      vis = (x < SHV) && (y < SVV);
      hw  = (x == SH - 1);
      vw  = hw && (y == SV - 1);
      ld  = (vis && (x % 8 == 7)) || hw;
      if (y >= SVV)     idx = SHV * SVV;
      else if (x < SHV) idx = y * SHV + x;
      else              idx = (y + 1) * SHV;
      on  = vis && row_m[7 - (x % 8)];
      col = on ? 8'hFF : 8'h00;
      exp_q.push_back(pack(10'(x), 10'(y), 19'(idx), vis, hw, vw, ld, col, col, col));
      g = 8'($urandom_range(0, 255));
      glyph_s = g;
      if (ld) row_m = g;
      sb_compare(c);
      if (s_vw === 1'b1) vw_seen++;
      step(1);
    end
  endtask

  typedef struct {
    logic [7:0] glyph;
    int         x;
    int         y;
    logic       vis;
    logic       hw;
    logic       ld;
    int         idx;
    logic [7:0] rgb;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int vw_seen;
    logic [7:0] row_a5;
    logic [30:0] exp_line, act_line;
    logic on;

    vecs[0]  = '{8'hA5,   0, 0, 1'b1, 1'b0, 1'b0,    0, 8'h00};
    vecs[1]  = '{8'hA5,   7, 0, 1'b1, 1'b0, 1'b1,    7, 8'h00};
    vecs[2]  = '{8'hA5,   8, 0, 1'b1, 1'b0, 1'b0,    8, 8'hFF};
    vecs[3]  = '{8'hA5,  10, 0, 1'b1, 1'b0, 1'b0,   10, 8'hFF};
    vecs[4]  = '{8'hA5,  11, 0, 1'b1, 1'b0, 1'b0,   11, 8'h00};
    vecs[5]  = '{8'hA5, 639, 0, 1'b1, 1'b0, 1'b1,  639, 8'hFF};
    vecs[6]  = '{8'hA5, 640, 0, 1'b0, 1'b0, 1'b0,  640, 8'h00};
    vecs[7]  = '{8'hA5, 799, 0, 1'b0, 1'b1, 1'b1,  640, 8'h00};
    vecs[8]  = '{8'hA5,   0, 1, 1'b1, 1'b0, 1'b0,  640, 8'hFF};
    vecs[9]  = '{8'hA5,   1, 1, 1'b1, 1'b0, 1'b0,  641, 8'h00};
    vecs[10] = '{8'hA5,   5, 1, 1'b1, 1'b0, 1'b0,  645, 8'hFF};
    vecs[11] = '{8'hA5,  15, 1, 1'b1, 1'b0, 1'b1,  655, 8'hFF};
    vecs[12] = '{8'hFF, 100, 1, 1'b1, 1'b0, 1'b0,  740, 8'hFF};
    vecs[13] = '{8'hFF, 640, 1, 1'b0, 1'b0, 1'b0, 1280, 8'h00};
    vecs[14] = '{8'hFF, 799, 1, 1'b0, 1'b1, 1'b1, 1280, 8'h00};
    vecs[15] = '{8'h00,   3, 1, 1'b1, 1'b0, 1'b0,  643, 8'h00};

    // table-driven vectors on the full-size raster
    for (int i = 0; i < 16; i++) begin
      glyph_f = vecs[i].glyph;
      do_reset();
      step(vecs[i].y * FH + vecs[i].x);
      check($sformatf("vec%0d_x", i),   32'(f_x),   vecs[i].x);
      check($sformatf("vec%0d_y", i),   32'(f_y),   vecs[i].y);
      check($sformatf("vec%0d_vis", i), 32'(f_vis), 32'(vecs[i].vis));
      check($sformatf("vec%0d_hw", i),  32'(f_hw),  32'(vecs[i].hw));
      check($sformatf("vec%0d_vw", i),  32'(f_vw),  32'h0);
      check($sformatf("vec%0d_ld", i),  32'(f_ld),  32'(vecs[i].ld));
      check($sformatf("vec%0d_idx", i), 32'(f_idx), vecs[i].idx);
      check($sformatf("vec%0d_r", i),   32'(f_r),   32'(vecs[i].rgb));
      check($sformatf("vec%0d_g", i),   32'(f_g),   32'(vecs[i].rgb));
      check($sformatf("vec%0d_b", i),   32'(f_b),   32'(vecs[i].rgb));
    end

    // first full line after reset with a constant A5 row
    row_a5 = 8'hA5;
    glyph_f = row_a5;
    do_reset();
    for (int x = 0; x < FH; x++) begin
      on = (x < FHV) && (x >= 8) && row_a5[7 - (x % 8)];
      exp_line = {10'(x), 10'd0, (x < FHV), (x == FH - 1),
                  ((x < FHV) && (x % 8 == 7)) || (x == FH - 1), on ? 8'hFF : 8'h00};
      act_line = {f_x, f_y, f_vis, f_hw, f_ld, f_r};
      check($sformatf("line0_x%0d", x), 32'(act_line), 32'(exp_line));
`ifdef SCAN_SYNC_OUTPUTS_EN
      check($sformatf("hsync_x%0d", x), 32'(f_hs), 32'(!((x >= 656) && (x <= 751))));
      check($sformatf("vsync_x%0d", x), 32'(f_vs), 32'h1);
`endif
      step(1);
    end
    check("line1_start_x", 32'(f_x), 0);
    check("line1_start_y", 32'(f_y), 1);

    // reset asserted mid-line with a lit row in the register
    glyph_f = 8'hFF;
    do_reset();
    step(FH + 300);
    check("pre_reset_x", 32'(f_x), 300);
    check("pre_reset_r", 32'(f_r), 32'hFF);
    reset = 1'b1;
    step(1);
    check("mid_reset_x",   32'(f_x),   0);
    check("mid_reset_y",   32'(f_y),   0);
    check("mid_reset_idx", 32'(f_idx), 0);
    check("mid_reset_r",   32'(f_r),   0);
    check("mid_reset_g",   32'(f_g),   0);
    check("mid_reset_b",   32'(f_b),   0);
`ifdef SCAN_SYNC_OUTPUTS_EN
    check("mid_reset_hsync", 32'(f_hs), 32'h1);
    check("mid_reset_vsync", 32'(f_vs), 32'h1);
`endif
    step(1);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("post_reset_x%0d", k), 32'(f_x), k);
      check($sformatf("post_reset_rgb%0d", k), 32'(f_g), (k == 8) ? 32'hFF : 32'h0);
      step(1);
    end

    // scoreboard stream over two reduced frames with random glyph rows
    run_small_stream(2 * SH * SV + 10, vw_seen);
    check("small_vwrap_count", 32'(vw_seen), 2);
    check("small_queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
